// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one pipelined memory port between an instruction requester and a
// data requester. Data wins ties. A stalled request stays locked until the
// memory grants it. An in-order owner FIFO routes each response to the
// requester that issued it. A flush squashes in-flight instruction fetches.
// A response that arrives with no transaction outstanding sets a sticky error.
//
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to enable the instruction
// starvation guard. After STARVE_LIMIT consecutive denied cycles, the
// instruction side wins the next arbitration.

module mem_port_arbiter #(
  parameter int MAX_OUT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  // instruction side
  input  logic        instr_req_ip,
  input  logic [31:0] instr_addr_ip,
  output logic        instr_gnt_op,
  output logic        instr_rvalid_op,
  output logic [31:0] instr_rdata_op,
  // data side
  input  logic        data_req_ip,
  input  logic        data_we_ip,
  input  logic [31:0] data_addr_ip,
  input  logic [31:0] data_wdata_ip,
  output logic        data_gnt_op,
  output logic        data_rvalid_op,
  output logic [31:0] data_rdata_op,
  // memory side
  output logic        mem_req_op,
  output logic        mem_we_op,
  output logic [31:0] mem_addr_op,
  output logic [31:0] mem_wdata_op,
  input  logic        mem_gnt_ip,
  input  logic        mem_rvalid_ip,
  input  logic [31:0] mem_rdata_ip,
  // control / status
  input  logic        flush_ip,
  output logic        resp_err_op
);

  typedef enum logic [1:0] {LOCK_NONE, LOCK_INSTR, LOCK_DATA} lock_e;

  localparam logic       OWN_INSTR = 1'b0;
  localparam logic       OWN_DATA  = 1'b1;
  localparam logic [2:0] MAX_CNT   = 3'(MAX_OUT);
  localparam logic [1:0] LAST_PTR  = 2'(MAX_OUT - 1);

  if (MAX_OUT < 1 || MAX_OUT > 4 || STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_param_check
    $error("mem_port_arbiter: MAX_OUT must be 1..4 and STARVE_LIMIT 1..255");
  end

  // Owner FIFO storage is sized for the largest legal MAX_OUT.
  // Pointers wrap at MAX_OUT-1.
  logic [3:0]  owner_q, owner_d;
  logic [3:0]  squash_q, squash_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  lock_e       lock_q, lock_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] instr_rdata_q, data_rdata_q;

  logic any_req, fifo_empty, pop, push, can_issue;
  logic instr_lock_live, data_lock_live, sel_data, starve_force;
  logic head_owner, head_squash;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
  endfunction

  // Arbitration, memory-side mux, grants and response routing.
  // All of these are zero-latency.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    any_req    = instr_req_ip | data_req_ip;
    fifo_empty = (count_q == 3'd0);
    pop        = mem_rvalid_ip & ~fifo_empty;
    // A response retiring this cycle frees its slot for a same-cycle grant.
    can_issue  = (count_q < MAX_CNT) | pop;
    mem_req_op = any_req & can_issue;

    // A flush releases an instruction lock immediately.
    instr_lock_live = (lock_q == LOCK_INSTR) & instr_req_ip & ~flush_ip;
    data_lock_live  = (lock_q == LOCK_DATA) & data_req_ip;

    if (instr_lock_live)                   sel_data = 1'b0;
    else if (data_lock_live)               sel_data = 1'b1;
    else if (starve_force && instr_req_ip) sel_data = 1'b0;
    else                                   sel_data = data_req_ip;

    push         = mem_req_op & mem_gnt_ip;
    data_gnt_op  = push & sel_data;
    instr_gnt_op = push & ~sel_data & ~flush_ip;

    mem_we_op    = 1'b0;
    mem_addr_op  = '0;
    mem_wdata_op = '0;
    if (any_req) begin
      if (sel_data) begin
        mem_we_op    = data_we_ip;
        mem_addr_op  = data_addr_ip;
        mem_wdata_op = data_wdata_ip;
      end else begin
        mem_addr_op  = instr_addr_ip;
      end
    end

    head_owner      = owner_q[rd_ptr_q];
    head_squash     = squash_q[rd_ptr_q];
    data_rvalid_op  = pop & (head_owner == OWN_DATA);
    instr_rvalid_op = pop & (head_owner == OWN_INSTR) & ~head_squash & ~flush_ip;
    data_rdata_op   = data_rvalid_op  ? mem_rdata_ip : data_rdata_q;
    instr_rdata_op  = instr_rvalid_op ? mem_rdata_ip : instr_rdata_q;
    resp_err_op     = resp_err_q;
  end

  // Next state for the lock, the owner FIFO, the count and the sticky error.
  always_comb begin
    lock_d = lock_q;
    if (push)                                  lock_d = LOCK_NONE;
    else if (mem_req_op)                       lock_d = sel_data ? LOCK_DATA
                                                      : (flush_ip ? LOCK_NONE : LOCK_INSTR);
    else if (!(instr_lock_live || data_lock_live)) lock_d = LOCK_NONE;

    owner_d  = owner_q;
    squash_d = squash_q;
    if (flush_ip) begin
      for (int i = 0; i < 4; i++) begin
        if (owner_q[i] == OWN_INSTR) squash_d[i] = 1'b1;
      end
    end
    // A fetch the memory accepts during a flush is tracked but pre-squashed.
    // Its response is still consumed in order.
    if (push) begin
      owner_d[wr_ptr_q]  = sel_data ? OWN_DATA : OWN_INSTR;
      squash_d[wr_ptr_q] = ~sel_data & flush_ip;
    end

    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    resp_err_d = resp_err_q | (mem_rvalid_ip & fifo_empty);
  end

  // State registers. The tiny owner FIFO is reset along with everything else.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the owner/squash array is only 8 flops, so resetting it is cheap and keeps X out of sim.
      owner_q       <= '0;
      squash_q      <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      lock_q        <= LOCK_NONE;
      resp_err_q    <= 1'b0;
      instr_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      owner_q       <= owner_d;
      squash_q      <= squash_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      lock_q        <= lock_d;
      resp_err_q    <= resp_err_d;
      instr_rdata_q <= instr_rdata_op;
      data_rdata_q  <= data_rdata_op;
    end
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt_q, starve_cnt_d;

  // Count consecutive cycles the pending instruction request loses arbitration.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!instr_req_ip || instr_gnt_op || flush_ip) starve_cnt_d = '0;
    else if (starve_cnt_q < STARVE_MAX)            starve_cnt_d = starve_cnt_q + 8'd1;
  end

  // Starvation counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end

  assign starve_force = (starve_cnt_q >= STARVE_MAX);
`else
  assign starve_force = 1'b0;
`endif

endmodule
